// File: rtl/jt51_wrqueue.sv
// jt51_wrqueue: host-side write buffer in front of the jt51 core.
// Queues (register address, data) pairs and replays each one as an address
// write followed by a data write. Strobes are timed to cen_p1, and the chip
// busy flag (dout[7]) is honoured before the next pair is issued.
// Optional feature macro: JT51_WRQ_TOUT_EN enables a busy watchdog that
// raises the sticky tout_err flag and forces the FSM back to IDLE.
`timescale 1ns/1ps

module jt51_wrqueue #(
    parameter int AW    = 4,
    parameter int GUARD = 2,
    parameter int TOUT  = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_p1,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [7:0]    wr_addr,
    input  logic [7:0]    wr_data,
    output logic [AW:0]   level,
    output logic          idle,
    output logic          ym_cs_n,
    output logic          ym_wr_n,
    output logic          ym_a0,
    output logic [7:0]    ym_din,
    input  logic [7:0]    ym_dout,
    output logic          tout_err,
    input  logic          tout_clr
);

    localparam int DEPTH = 1 << AW;
    localparam int GW    = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_GUARD,
        ST_WAITB
    } state_t;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push;
    logic          pop;
    logic [15:0]   head;

    state_t        state_q;
    state_t        state_d;
    logic [GW-1:0] guardCnt_q;
    logic [GW-1:0] guardCnt_d;
    logic [7:0]    dataHold_q;
    logic [7:0]    dataHold_d;
    logic          strobe_q;
    logic          strobe_d;
    logic          a0_q;
    logic          a0_d;
    logic [7:0]    din_q;
    logic [7:0]    din_d;
    logic [6:0]    dout_unused;

    // wr_ready looks only at the registered count, so a full FIFO stays
    // closed even in a cycle where the FSM is popping.
    assign wr_ready    = (count_q != (AW + 1)'(DEPTH));
    assign push        = wr_valid & wr_ready;
    assign pop         = (state_q == ST_IDLE) && (count_q != '0);
    assign head        = mem_q[rdPtr_q];
    assign level       = count_q;
    assign idle        = (state_q == ST_IDLE) && (count_q == '0);
    assign ym_cs_n     = strobe_q;
    assign ym_wr_n     = strobe_q;
    assign ym_a0       = a0_q;
    assign ym_din      = din_q;
    assign dout_unused = ym_dout[6:0];

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {wr_addr, wr_data};
        end
    end

    // Occupancy update: push and pop together leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; reset drops every stored pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

`ifdef JT51_WRQ_TOUT_EN
    localparam int TW = $clog2(TOUT + 1);

    logic [TW-1:0] toutCnt_q;
    logic [TW-1:0] toutCnt_d;
    logic          toutErr_q;
    logic          toutErr_d;
    logic          toutFire;
`else
    logic [1:0]    tout_unused;

    assign tout_unused = {tout_clr, (TOUT > 0)};
`endif

    // Sequencer: pops a pair in IDLE, then walks address strobe, gap,
    // data strobe, guard delay and busy wait, moving on cen_p1 ticks only
    always_comb begin
        state_d    = state_q;
        guardCnt_d = guardCnt_q;
        dataHold_d = dataHold_q;
        a0_d       = a0_q;
        din_d      = din_q;
`ifdef JT51_WRQ_TOUT_EN
        toutFire   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d    = ST_ADDR;
                    a0_d       = 1'b0;
                    din_d      = head[15:8];
                    dataHold_d = head[7:0];
                end
            end
            ST_ADDR: begin
                if (cen_p1) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cen_p1) begin
                    state_d = ST_DATA;
                    a0_d    = 1'b1;
                    din_d   = dataHold_q;
                end
            end
            ST_DATA: begin
                if (cen_p1) begin
                    state_d    = ST_GUARD;
                    guardCnt_d = GW'(GUARD);
                end
            end
            ST_GUARD: begin
                if (cen_p1) begin
                    if (guardCnt_q <= GW'(1)) begin
                        state_d = ST_WAITB;
                    end else begin
                        guardCnt_d = guardCnt_q - GW'(1);
                    end
                end
            end
            ST_WAITB: begin
                if (cen_p1) begin
                    if (!ym_dout[7]) begin
                        state_d = ST_IDLE;
                    end
`ifdef JT51_WRQ_TOUT_EN
                    else if (toutCnt_q == TW'(TOUT - 1)) begin
                        state_d  = ST_IDLE;
                        toutFire = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        strobe_d = !((state_d == ST_ADDR) || (state_d == ST_DATA));
    end

    // State and registered chip-side outputs; strobes rise asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            guardCnt_q <= '0;
            dataHold_q <= '0;
            strobe_q   <= 1'b1;
            a0_q       <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            guardCnt_q <= guardCnt_d;
            dataHold_q <= dataHold_d;
            strobe_q   <= strobe_d;
            a0_q       <= a0_d;
            din_q      <= din_d;
        end
    end

`ifdef JT51_WRQ_TOUT_EN
    // Watchdog counter restarts on entry to WAITB; a new timeout beats tout_clr
    always_comb begin
        toutCnt_d = toutCnt_q;
        if (state_d == ST_WAITB) begin
            if (state_q != ST_WAITB) begin
                toutCnt_d = '0;
            end else if (cen_p1) begin
                toutCnt_d = toutCnt_q + 1'b1;
            end
        end
        toutErr_d = toutFire ? 1'b1 : (tout_clr ? 1'b0 : toutErr_q);
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toutCnt_q <= '0;
            toutErr_q <= 1'b0;
        end else begin
            toutCnt_q <= toutCnt_d;
            toutErr_q <= toutErr_d;
        end
    end

    assign tout_err = toutErr_q;
`else
    assign tout_err = 1'b0;
`endif

endmodule
